apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master.sv | 233 +++++++++++++++++++++++
 tb/tb_apb4_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
// apb4_master: command FIFO in front of a single-outstanding APB4 requester.
// Commands are queued, issued one at a time as SETUP/ACCESS phases to the slave
// chosen by the top address bits, and the slave's answer is returned on the
// response channel.
// Optional feature: define APB4_MASTER_TIMEOUT_EN to abort transfers that sit
// in ACCESS for TIMEOUT wait-state cycles. Left undefined, ACCESS waits forever.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid && ready are both 1; the source holds valid and payload stable until
// then, and ready never depends on valid in the same cycle.
module apb4_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NSLV       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  input  logic                   i_cmd_write,
  input  logic [DATA_W-1:0]      i_cmd_wdata,
  input  logic [DATA_W/8-1:0]    i_cmd_strb,
  input  logic [2:0]             i_cmd_prot,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_W-1:0]      o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_rsp_timeout,
  output logic [ADDR_W-1:0]      PADDR,
  output logic                   PWRITE,
  output logic [DATA_W-1:0]      PWDATA,
  output logic [DATA_W/8-1:0]    PSTRB,
  output logic [2:0]             PPROT,
  output logic [NSLV-1:0]        PSELx,
  output logic                   PENABLE,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR,
  output logic [1:0]             o_dbg_state
);

  localparam int SW = $clog2(NSLV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_W / 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [BW-1:0]     fifo_strb  [FIFO_DEPTH];
  logic [2:0]        fifo_prot  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              ready_en;
  logic              push, pop, fifo_empty, rsp_hs;
  logic [ADDR_W-1:0] head_addr;
  logic              head_write;
  logic [DATA_W-1:0] head_wdata;
  logic [BW-1:0]     head_strb;
  logic [2:0]        head_prot;
  logic [SW-1:0]     head_idx, sel_idx;
  logic [NSLV-1:0]   head_sel;
  logic              pready_sel, pslverr_sel;
  logic [DATA_W-1:0] prdata_sel;

  // ready_en keeps o_cmd_ready low until the first edge after reset release.
  assign o_cmd_ready = ready_en && (count < DEPTH_C);
  assign push        = i_cmd_valid && o_cmd_ready;
  assign fifo_empty  = (count == '0);
  assign rsp_hs      = o_rsp_valid && i_rsp_ready;
  assign pop         = !fifo_empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_hs));
  assign o_dbg_state = state;

  assign head_addr  = fifo_addr[rd_ptr];
  assign head_write = fifo_write[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  assign head_strb  = fifo_strb[rd_ptr];
  assign head_prot  = fifo_prot[rd_ptr];
  assign head_idx   = head_addr[ADDR_W-1 -: SW];
  assign head_sel   = {{(NSLV-1){1'b0}}, 1'b1} << head_idx;

  // Only the selected slave's return signals are ever looked at.
  assign pready_sel  = PREADY[sel_idx];
  assign pslverr_sel = PSLVERR[sel_idx];

  // Pick the read-data slice of the selected slave.
  always_comb begin
    prdata_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_idx == SW'(k)) prdata_sel = PRDATA[k*DATA_W +: DATA_W];
    end
  end

  // Command acceptance is enabled one edge after reset is released.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ready_en <= 1'b0;
    else            ready_en <= 1'b1;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while count says the slot is free.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= i_cmd_addr;
      fifo_write[wr_ptr] <= i_cmd_write;
      fifo_wdata[wr_ptr] <= i_cmd_wdata;
      fifo_strb[wr_ptr]  <= i_cmd_strb;
      fifo_prot[wr_ptr]  <= i_cmd_prot;
    end
  end

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_C = 16'(TIMEOUT);
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        rsp_tmo_q;

  // Abort on the ACCESS cycle that would bring the wait count up to TIMEOUT.
  assign tmo_hit = (state == S_ACCESS) && !pready_sel && ((tmo_cnt + 16'd1) == TMO_C);

  // Wait-state counter: cleared in SETUP, counts ACCESS cycles without PREADY.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                             tmo_cnt <= '0;
    else if (state == S_SETUP)                  tmo_cnt <= '0;
    else if ((state == S_ACCESS) && !pready_sel) tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign o_rsp_timeout = rsp_tmo_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  // Transfer FSM and all registered APB/response outputs; a pop loads the APB
  // request registers so SETUP starts with the new command already on the bus.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      PSELx       <= '0;
      PENABLE     <= 1'b0;
      sel_idx     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_sel) begin
            PSELx       <= '0;
            PENABLE     <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= PWRITE ? '0 : prdata_sel;
            o_rsp_err   <= pslverr_sel;
`ifdef APB4_MASTER_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
`endif
            state       <= S_RESP;
          end
`ifdef APB4_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            PSELx       <= '0;
            PENABLE     <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            state       <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (rsp_hs) begin
            o_rsp_valid <= 1'b0;
            state       <= fifo_empty ? S_IDLE : S_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (pop) begin
        PADDR   <= head_addr;
        PWRITE  <= head_write;
        PWDATA  <= head_wdata;
        PSTRB   <= head_write ? head_strb : '0;
        PPROT   <= head_prot;
        PSELx   <= head_sel;
        sel_idx <= head_idx;
        PENABLE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master (32-bit address/data, 4 slaves, 4-deep FIFO,
// TIMEOUT=8). Slave k's read data is the word in PRDATA[k*32 +: 32].
module tb_apb4_master;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_t;

  logic         i_clk, i_reset_n;
  logic         i_cmd_valid, o_cmd_ready;
  logic [31:0]  i_cmd_addr;
  logic         i_cmd_write;
  logic [31:0]  i_cmd_wdata;
  logic [3:0]   i_cmd_strb;
  logic [2:0]   i_cmd_prot;
  logic         o_rsp_valid, i_rsp_ready;
  logic [31:0]  o_rsp_rdata;
  logic         o_rsp_err, o_rsp_timeout;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [2:0]   PPROT;
  logic [3:0]   PSELx;
  logic         PENABLE;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;
  logic [1:0]   o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  cmd_t        cmd_q[$];
  logic [31:0] exp_addr_q[$];
  logic [33:0] exp_q[$];      // {timeout, err, rdata}

  apb4_master #(
    .ADDR_W(32), .DATA_W(32), .NSLV(4), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_write(i_cmd_write), .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_strb(i_cmd_strb), .i_cmd_prot(i_cmd_prot),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PSELx(PSELx), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic [31:0] addr, input logic write,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic [2:0] prot);
    cmd_t c;
    c.addr = addr; c.write = write; c.wdata = wdata; c.strb = strb; c.prot = prot;
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    i_cmd_addr  = c.addr;
    i_cmd_write = c.write;
    i_cmd_wdata = c.wdata;
    i_cmd_strb  = c.strb;
    i_cmd_prot  = c.prot;
    i_cmd_valid = 1'b1;
  endtask

  // Feeds cmd_q into the DUT and scoreboards SETUP addresses and responses
  // against exp_addr_q / exp_q until everything drains or the budget runs out.
  task automatic run_traffic(input int max_cycles);
    logic        accepted;
    logic [31:0] ea;
    logic [3:0]  esel;
    for (int c = 0; c < max_cycles; c++) begin
      if (cmd_q.size() == 0 && exp_q.size() == 0) break;
      if (cmd_q.size() > 0) drive_cmd(cmd_q[0]);
      else                  i_cmd_valid = 1'b0;
      accepted = i_cmd_valid && o_cmd_ready;
      if (o_dbg_state == S_SETUP) begin
        check("setup_expected", 64'(exp_addr_q.size() > 0), 64'd1);
        if (exp_addr_q.size() > 0) begin
          ea   = exp_addr_q.pop_front();
          esel = 4'b0001 << ea[31:30];
          check("setup_paddr", PADDR, ea);
          check("setup_psel", PSELx, esel);
          check("setup_penable", PENABLE, 1'b0);
        end
      end
      if (o_rsp_valid && i_rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          check("rsp_payload", {o_rsp_timeout, o_rsp_err, o_rsp_rdata}, exp_q.pop_front());
      end
      tick();
      if (accepted) void'(cmd_q.pop_front());
    end
    i_cmd_valid = 1'b0;
    check("drain_rsp_left", exp_q.size(), 0);
    check("drain_cmd_left", cmd_q.size(), 0);
    check("drain_addr_left", exp_addr_q.size(), 0);
  endtask

  // Directed sequence
  initial begin
    cmd_t c;
    logic [31:0] fill_addr [4];

    i_reset_n   = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_write = 1'b0;
    i_cmd_wdata = '0;
    i_cmd_strb  = '0;
    i_cmd_prot  = '0;
    i_rsp_ready = 1'b0;
    PRDATA      = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    PREADY      = 4'b0000;
    PSLVERR     = 4'b0000;

    // ---- reset values ----
    tick(); tick();
    check("rst_state", o_dbg_state, S_IDLE);
    check("rst_psel", PSELx, 4'b0000);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_timeout", o_rsp_timeout, 1'b0);
    check("rst_cmd_ready", o_cmd_ready, 1'b0);
    i_reset_n = 1'b1;
    check("release_ready_low", o_cmd_ready, 1'b0);
    tick();
    check("release_ready_high", o_cmd_ready, 1'b1);

    // ---- single write, zero wait states; addr[31:30]=01 selects slave 1 ----
    PREADY = 4'b0010;
    i_rsp_ready = 1'b1;
    drive_cmd(mk_cmd(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd2));
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check("wr_setup_state", o_dbg_state, S_SETUP);
    check("wr_setup_psel", PSELx, 4'b0010);
    check("wr_setup_penable", PENABLE, 1'b0);
    check("wr_setup_paddr", PADDR, 32'h4000_0010);
    check("wr_setup_pwrite", PWRITE, 1'b1);
    check("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("wr_setup_pstrb", PSTRB, 4'hF);
    check("wr_setup_pprot", PPROT, 3'd2);
    tick();
    check("wr_access_state", o_dbg_state, S_ACCESS);
    check("wr_access_psel", PSELx, 4'b0010);
    check("wr_access_penable", PENABLE, 1'b1);
    tick();
    check("wr_resp_state", o_dbg_state, S_RESP);
    check("wr_resp_valid", o_rsp_valid, 1'b1);
    check("wr_resp_rdata", o_rsp_rdata, 32'h0);
    check("wr_resp_err", o_rsp_err, 1'b0);
    check("wr_resp_psel", PSELx, 4'b0000);
    check("wr_resp_penable", PENABLE, 1'b0);
    tick();
    check("wr_done_state", o_dbg_state, S_IDLE);
    check("wr_done_valid", o_rsp_valid, 1'b0);

    // ---- read from slave 3 with three wait states; other slaves ready/erroring ----
    PRDATA      = {32'h1234_5678, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    PREADY      = 4'b0111;
    PSLVERR     = 4'b0111;
    i_rsp_ready = 1'b0;
    drive_cmd(mk_cmd(32'hC000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'd1));
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check("rd_setup_psel", PSELx, 4'b1000);
    check("rd_setup_penable", PENABLE, 1'b0);
    check("rd_setup_pstrb", PSTRB, 4'h0);
    check("rd_setup_pwrite", PWRITE, 1'b0);
    check("rd_setup_pprot", PPROT, 3'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_state", o_dbg_state, S_ACCESS);
      check("rd_wait_psel", PSELx, 4'b1000);
      check("rd_wait_penable", PENABLE, 1'b1);
      check("rd_wait_paddr", PADDR, 32'hC000_0004);
      check("rd_wait_pstrb", PSTRB, 4'h0);
      check("rd_wait_rsp_valid", o_rsp_valid, 1'b0);
      tick();
    end
    check("rd_last_access", o_dbg_state, S_ACCESS);
    PREADY = 4'b1111;
    tick();
    check("rd_resp_valid", o_rsp_valid, 1'b1);
    check("rd_resp_rdata", o_rsp_rdata, 32'h1234_5678);
    check("rd_resp_err", o_rsp_err, 1'b0);
    check("rd_resp_psel", PSELx, 4'b0000);
    tick();
    check("rd_hold_valid", o_rsp_valid, 1'b1);
    check("rd_hold_rdata", o_rsp_rdata, 32'h1234_5678);
    i_rsp_ready = 1'b1;
    tick();
    check("rd_done_state", o_dbg_state, S_IDLE);
    check("rd_done_valid", o_rsp_valid, 1'b0);

    // ---- FIFO fill behind a stalled response, then drain in order ----
    PRDATA      = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    PREADY      = 4'b1111;
    PSLVERR     = 4'b0000;
    i_rsp_ready = 1'b0;
    drive_cmd(mk_cmd(32'h0000_0040, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd0));
    tick();
    i_cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("fill_stall_state", o_dbg_state, S_RESP);
    check("fill_stall_valid", o_rsp_valid, 1'b1);
    fill_addr[0] = 32'h0000_0100;
    fill_addr[1] = 32'h4000_0200;
    fill_addr[2] = 32'h8000_0300;
    fill_addr[3] = 32'hC000_0400;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(mk_cmd(fill_addr[i], 1'b0, 32'h0, 4'hF, 3'd0));
      check("fill_ready_open", o_cmd_ready, 1'b1);
      tick();
    end
    c = mk_cmd(32'h4000_0500, 1'b0, 32'h0, 4'hF, 3'd0);
    drive_cmd(c);
    check("fill_ready_full", o_cmd_ready, 1'b0);
    tick();
    check("fill_ready_still_full", o_cmd_ready, 1'b0);
    check("fill_still_resp", o_dbg_state, S_RESP);
    cmd_q.push_back(c);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(fill_addr[i]);
    exp_addr_q.push_back(32'h4000_0500);
    exp_q.push_back({2'b00, 32'h0});
    exp_q.push_back({2'b00, 32'h1111_1111});
    exp_q.push_back({2'b00, 32'h2222_2222});
    exp_q.push_back({2'b00, 32'h3333_3333});
    exp_q.push_back({2'b00, 32'h4444_4444});
    exp_q.push_back({2'b00, 32'h2222_2222});
    i_rsp_ready = 1'b1;
    run_traffic(60);
    check("fill_end_state", o_dbg_state, S_IDLE);

    // ---- slave error on slave 1, following write still issued ----
    PSLVERR = 4'b0010;
    cmd_q.push_back(mk_cmd(32'h4000_0008, 1'b0, 32'h0, 4'hF, 3'd0));
    cmd_q.push_back(mk_cmd(32'h8000_000C, 1'b1, 32'h0000_55AA, 4'h3, 3'd0));
    exp_addr_q.push_back(32'h4000_0008);
    exp_addr_q.push_back(32'h8000_000C);
    exp_q.push_back({2'b01, 32'h2222_2222});
    exp_q.push_back({2'b00, 32'h0});
    run_traffic(40);
    PSLVERR = 4'b0000;

    // ---- slave 2 never ready ----
    PREADY = 4'b0000;
    drive_cmd(mk_cmd(32'h8000_0000, 1'b0, 32'h0, 4'hF, 3'd0));
    tick();
    i_cmd_valid = 1'b0;
    tick(); tick();
    check("stall_first_access", o_dbg_state, S_ACCESS);
`ifdef APB4_MASTER_TIMEOUT_EN
    repeat (7) tick();
    check("tmo_eighth_access", o_dbg_state, S_ACCESS);
    check("tmo_eighth_valid", o_rsp_valid, 1'b0);
    tick();
    check("tmo_resp_state", o_dbg_state, S_RESP);
    check("tmo_resp_valid", o_rsp_valid, 1'b1);
    check("tmo_resp_err", o_rsp_err, 1'b1);
    check("tmo_resp_timeout", o_rsp_timeout, 1'b1);
    check("tmo_resp_rdata", o_rsp_rdata, 32'h0);
    check("tmo_resp_psel", PSELx, 4'b0000);
    check("tmo_resp_penable", PENABLE, 1'b0);
    tick();
`else
    repeat (97) tick();
    check("notmo_state_c100", o_dbg_state, S_ACCESS);
    check("notmo_psel_c100", PSELx, 4'b0100);
    check("notmo_penable_c100", PENABLE, 1'b1);
    check("notmo_valid_c100", o_rsp_valid, 1'b0);
    check("notmo_timeout_c100", o_rsp_timeout, 1'b0);
    PREADY = 4'b0100;
    tick();
    check("notmo_resp_rdata", o_rsp_rdata, 32'h3333_3333);
    check("notmo_resp_err", o_rsp_err, 1'b0);
    tick();
`endif
    check("stall_end_state", o_dbg_state, S_IDLE);

    // ---- reset during ACCESS with one more command queued ----
    PREADY = 4'b0000;
    drive_cmd(mk_cmd(32'h4000_0000, 1'b0, 32'h0, 4'hF, 3'd0));
    tick();
    drive_cmd(mk_cmd(32'h8000_0000, 1'b1, 32'h1, 4'hF, 3'd0));
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check("mid_access_state", o_dbg_state, S_ACCESS);
    check("mid_access_psel", PSELx, 4'b0010);
    i_reset_n = 1'b0;
    #1;
    check("async_rst_psel", PSELx, 4'b0000);
    check("async_rst_penable", PENABLE, 1'b0);
    check("async_rst_valid", o_rsp_valid, 1'b0);
    check("async_rst_ready", o_cmd_ready, 1'b0);
    check("async_rst_state", o_dbg_state, S_IDLE);
    tick(); tick();
    i_reset_n = 1'b1;
    PREADY = 4'b1111;
    check("post_rst_ready_low", o_cmd_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ready", o_cmd_ready, 1'b1);
      check("post_rst_idle", o_dbg_state, S_IDLE);
      check("post_rst_no_rsp", o_rsp_valid, 1'b0);
      check("post_rst_psel", PSELx, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
